// File: rtl/fp_dly_pipe.sv
// Valid-tagged delay line with a runtime-selectable tap, stall, flush and an in-flight counter.
// Aligns FP operands or side-band data with the latency of pipelined FP operators.
module fp_dly_pipe #(
   parameter  int WIDTH         = 33,
   parameter  int MAX_DELAY     = 16,
   parameter  int DEFAULT_DELAY = 12,
   localparam int SW            = $clog2(MAX_DELAY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             dly_load,
   input  logic [SW-1:0]    dly_sel,
   output logic             dly_ack,
   output logic             dly_err,
   output logic [SW-1:0]    cur_dly,
   output logic [SW-1:0]    inflight,
   output logic             busy
);

   localparam logic [SW-1:0] MAX_SEL = SW'(MAX_DELAY);
   localparam logic [SW-1:0] DEF_SEL = SW'(DEFAULT_DELAY);
   localparam logic [SW-1:0] ONE     = SW'(1);

   logic [WIDTH-1:0]     s_data [MAX_DELAY];
   logic [MAX_DELAY-1:0] s_valid;
   logic                 load_ok;

   // Output tap s[cur_dly-1], selected by compare so no index is wider than the array needs.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
         if (cur_dly == SW'(i + 1)) begin
            out_valid = s_valid[i];
            out_data  = s_data[i];
         end
      end
   end

   // A flush on the same cycle empties the pipe, so it stands in for "idle, no input".
   assign load_ok = dly_load && (dly_sel != '0) && (dly_sel <= MAX_SEL)
                    && ((inflight == '0) || flush)
                    && !(en && in_valid && !flush);

   assign busy = (inflight != '0);

   // NOTE: the stage array is a bank of flops, not a RAM, so an async reset on it is legal
   // and cheap; all state here uses non-blocking assignment so every stage reads the
   // pre-edge value of its neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DELAY; i++) s_data[i] <= '0;
         s_valid  <= '0;
         cur_dly  <= DEF_SEL;
         inflight <= '0;
         dly_ack  <= 1'b0;
         dly_err  <= 1'b0;
      end else begin
         dly_ack <= load_ok;
         dly_err <= dly_load && !load_ok;
         if (load_ok) begin
            // Clearing every valid bit keeps stale samples past the old tap from surfacing.
            cur_dly  <= dly_sel;
            s_valid  <= '0;
            inflight <= '0;
         end else if (flush) begin
            s_valid  <= '0;
            inflight <= '0;
         end else if (en) begin
            s_data[0]  <= in_data;
            s_valid[0] <= in_valid;
            for (int i = 1; i < MAX_DELAY; i++) begin
               s_data[i]  <= s_data[i-1];
               s_valid[i] <= s_valid[i-1];
            end
            case ({in_valid, out_valid})
               2'b10:   inflight <= inflight + ONE;
               2'b01:   inflight <= inflight - ONE;
               default: inflight <= inflight;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fp_dly_pipe.sv
// Scoreboard bench for fp_dly_pipe: driver updates an age-based reference model at each edge,
// a negedge monitor compares every DUT output against it.
module tb_fp_dly_pipe;

   localparam int WIDTH = 33;
   localparam int MAXD  = 16;
   localparam int DEFD  = 12;
   localparam int SW    = $clog2(MAXD + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             en, flush, in_valid, dly_load;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    dly_sel;
   logic             out_valid, dly_ack, dly_err, busy;
   logic [WIDTH-1:0] out_data;
   logic [SW-1:0]    cur_dly, inflight;

   fp_dly_pipe #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data),
      .dly_load(dly_load), .dly_sel(dly_sel),
      .dly_ack(dly_ack), .dly_err(dly_err),
      .cur_dly(cur_dly), .inflight(inflight), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               age;    // enabled edges since capture
   } fly_t;

   fly_t             fly[$];    // reference model of samples inside the active window
   logic [WIDTH-1:0] exp_q[$];  // scoreboard of expected output data, in order
   int               m_dly;
   bit               exp_ack, exp_err;
   bit               mon_on = 1'b0;
   int               n_checks = 0;
   int               n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fly.delete();
      exp_q.delete();
      m_dly   = DEFD;
      exp_ack = 1'b0;
      exp_err = 1'b0;
   endtask

   // Reference behaviour of one clock edge, from the pre-edge inputs.
   task automatic model_step(input bit e, input bit f, input bit v, input logic [WIDTH-1:0] d,
                             input bit ld, input int sel);
      bit accept;
      accept  = ld && sel >= 1 && sel <= MAXD && (fly.size() == 0 || f) && !(e && v && !f);
      exp_ack = accept;
      exp_err = ld && !accept;
      if (accept) begin
         m_dly = sel;
         fly.delete();
         exp_q.delete();
      end else if (f) begin
         fly.delete();
         exp_q.delete();
      end else if (e) begin
         if (fly.size() > 0 && fly[0].age == m_dly - 1) void'(fly.pop_front());
         foreach (fly[i]) fly[i].age++;
         if (v) begin
            fly.push_back('{data: d, age: 0});
            exp_q.push_back(d);
         end
      end
   endtask

   task automatic cyc(input bit e, input bit f, input bit v, input logic [WIDTH-1:0] d,
                      input bit ld, input int sel);
      en = e; flush = f; in_valid = v; in_data = d; dly_load = ld; dly_sel = SW'(sel);
      @(posedge clk);
      model_step(e, f, v, d, ld, sel);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0, 0);
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_cur_dly",   cur_dly,   DEFD);
      check("rst_inflight",  inflight,  0);
      check("rst_busy",      busy,      0);
      check("rst_dly_ack",   dly_ack,   0);
      check("rst_dly_err",   dly_err,   0);
   endtask

   // Monitor: compares every cycle, consumes the scoreboard head when the DUT delivers.
   initial begin
      bit exp_valid;
      forever begin
         @(negedge clk);
         if (mon_on && !rst) begin
            exp_valid = fly.size() > 0 && fly[0].age == m_dly - 1;
            check("out_valid", out_valid, exp_valid);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL out_data: got %0h with empty scoreboard at %0t", out_data, $time);
               end else begin
                  check("out_data", out_data, exp_q[0]);
                  if (en && !flush) void'(exp_q.pop_front());
               end
            end
            check("inflight", inflight, fly.size());
            check("busy",     busy,     fly.size() != 0);
            check("cur_dly",  cur_dly,  m_dly);
            check("dly_ack",  dly_ack,  exp_ack);
            check("dly_err",  dly_err,  exp_err);
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] d;
      rst = 1'b1;
      en = 0; flush = 0; in_valid = 0; in_data = '0; dly_load = 0; dly_sel = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      rst    = 1'b0;
      mon_on = 1'b1;

      // Single sample at default delay.
      cyc(1, 0, 1, 33'h1_3F80_0000, 0, 0);
      idle(15);

      // Continuous stream of 20 indexed samples.
      for (int i = 0; i < 20; i++) cyc(1, 0, 1, WIDTH'(i), 0, 0);
      idle(14);

      // Four samples, then a five-cycle stall mid-flight.
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, WIDTH'(100 + i), 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, WIDTH'(200 + i), 0, 0);
      idle(16);

      // Six-cycle stream with a flush on the fourth cycle; its own sample is dropped.
      for (int i = 0; i < 6; i++) cyc(1, i == 3, 1, WIDTH'(300 + i), 0, 0);
      idle(16);

      // Delay changes on an idle pipe, then illegal selects.
      cyc(1, 0, 0, '0, 1, 3);
      cyc(1, 0, 1, 33'h0_4049_0FDB, 0, 0);
      idle(5);
      cyc(1, 0, 0, '0, 1, 0);
      cyc(1, 0, 0, '0, 1, 17);
      cyc(1, 0, 0, '0, 1, 3);
      cyc(1, 0, 0, '0, 1, 1);
      cyc(1, 0, 1, 33'h1_0000_0001, 0, 0);
      idle(2);
      cyc(1, 0, 0, '0, 1, 3);

      // Busy pipe rejects the load; the same load with flush is accepted.
      cyc(1, 0, 1, WIDTH'(400), 0, 0);
      cyc(1, 0, 1, WIDTH'(401), 0, 0);
      cyc(1, 0, 0, '0, 1, 16);
      cyc(1, 1, 0, '0, 1, 16);
      idle(18);

      // Colliding input sample on an idle pipe is rejected.
      cyc(1, 0, 1, WIDTH'(500), 1, 5);
      idle(17);

      // Randomized traffic across all controls.
      for (int i = 0; i < 1500; i++) begin
         d = {1'($urandom_range(0, 1)), 32'($urandom)};
         cyc($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 60, d,
             $urandom_range(0, 99) < 4,
             ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 18)));
      end

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, WIDTH'(600 + i), 0, 0);
      #2;
      rst    = 1'b1;
      mon_on = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_on = 1'b1;
      cyc(1, 0, 1, WIDTH'(700), 0, 0);
      idle(14);

      mon_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
